// File: rtl/seg_scan_if.sv
// seg_scan_if: load/display bus for the eight-digit seven-segment scanner
interface seg_scan_if;
  logic [31:0] DATA;
  logic [7:0]  DP;
  logic [7:0]  EN;
  logic        LOAD;
  logic        UPDATED;
  logic [7:0]  CA;
  logic [7:0]  AN;
  modport master (output DATA, DP, EN, LOAD, input UPDATED, CA, AN);
  modport slave  (input DATA, DP, EN, LOAD, output UPDATED, CA, AN);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 8-digit hex display driver with frame-synchronous double buffering
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input logic       CLK,
  input logic       RST,
  seg_scan_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  // 7-bit active-low glyphs for 0..F, digit 0 in the low bits
  localparam logic [111:0] SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d, upd_q, upd_d;
  logic [31:0]   pdata_q, pdata_d, adata_q, adata_d;
  logic [7:0]    pdp_q, pdp_d, pen_q, pen_d, adp_q, adp_d, aen_q, aen_d;
  logic [7:0]    ca_q, ca_d, an_q, an_d;
  logic          tick, bnd, blank, show;
  logic [3:0]    nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0]    msd;
`endif
  always_comb begin
    tick    = pre_q == PW'(REFRESH_DIV - 1);
    bnd     = tick && idx_q == 3'd7;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    idx_d   = idx_q + {2'b0, tick};
    pend_d  = !bnd && (bus.LOAD || pend_q);
    pdata_d = (bus.LOAD && !bnd) ? bus.DATA : pdata_q;
    pdp_d   = (bus.LOAD && !bnd) ? bus.DP : pdp_q;
    pen_d   = (bus.LOAD && !bnd) ? bus.EN : pen_q;
    // a boundary LOAD bypasses the pending buffer and wins over older pending data
    adata_d = !bnd ? adata_q : bus.LOAD ? bus.DATA : pend_q ? pdata_q : adata_q;
    adp_d   = !bnd ? adp_q : bus.LOAD ? bus.DP : pend_q ? pdp_q : adp_q;
    aen_d   = !bnd ? aen_q : bus.LOAD ? bus.EN : pend_q ? pen_q : aen_q;
    upd_d   = bnd && (bus.LOAD || pend_q);
    nib     = adata_d[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    msd = 3'd0;
    for (int k = 1; k < 8; k++)
      if (adata_d[4*k +: 4] != 4'd0) msd = 3'(k);
    blank = idx_d > msd && !adp_d[idx_d];
`else
    blank = 1'b0;
`endif
    show = aen_d[idx_d] && !blank;
    an_d = show ? ~(8'b1 << idx_d) : 8'hFF;
    ca_d = show ? {~adp_d[idx_d], SEG[7*nib +: 7]} : 8'hFF;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      pdata_q <= '0;
      pdp_q   <= '0;
      pen_q   <= '0;
      adata_q <= '0;
      adp_q   <= '0;
      aen_q   <= '0;
      ca_q    <= 8'hFF;
      an_q    <= 8'hFF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      pdata_q <= pdata_d;
      pdp_q   <= pdp_d;
      pen_q   <= pen_d;
      adata_q <= adata_d;
      adp_q   <= adp_d;
      aen_q   <= aen_d;
      ca_q    <= ca_d;
      an_q    <= an_d;
    end
  end
  assign bus.CA      = ca_q;
  assign bus.AN      = an_q;
  assign bus.UPDATED = upd_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed plus random checks of seg_scan against a cycle-count based display model
module tb_seg_scan;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_scan_if bus ();
  seg_scan #(.REFRESH_DIV(D)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, upd_cnt = 0;
  logic [7:0] seen = 8'h00;
  logic [7:0] segt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  // model: cycles since reset determine prescaler and digit; frames hold the active contents
  int mcyc = 0;
  logic [31:0] madata = 0, mpdata = 0;
  logic [7:0] madp = 0, maen = 0, mpdp = 0, mpen = 0;
  bit mpend = 0, mupd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_disp();
    int idx = (mcyc / D) % 8;
    int nib = (madata >> (4 * idx)) & 15;
    bit show = maen[idx];
`ifdef LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int k = 0; k < 8; k++)
      if (((madata >> (4 * k)) & 15) != 0) msd = k;
    if (idx > msd && !madp[idx]) show = 0;
`endif
    if (!show) return 16'hFFFF;
    return {madp[idx] ? (segt[nib] & 8'h7F) : segt[nib], an_tab[idx]};
  endfunction

  task automatic step();
    logic [15:0] e;
    if (rst) begin
      mcyc = 0; madata = 0; mpdata = 0; madp = 0; maen = 0;
      mpdp = 0; mpen = 0; mpend = 0; mupd = 0;
    end else begin
      if (mcyc % D == D - 1 && (mcyc / D) % 8 == 7) begin
        mupd = bus.LOAD || mpend;
        if (bus.LOAD) begin madata = bus.DATA; madp = bus.DP; maen = bus.EN; end
        else if (mpend) begin madata = mpdata; madp = mpdp; maen = mpen; end
        mpend = 0;
      end else begin
        mupd = 0;
        if (bus.LOAD) begin mpdata = bus.DATA; mpdp = bus.DP; mpen = bus.EN; mpend = 1; end
      end
      mcyc++;
    end
    @(posedge clk);
    #1;
    e = model_disp();
    chk("ca", bus.CA, e[15:8]);
    chk("an", bus.AN, e[7:0]);
    chk("updated", bus.UPDATED, mupd);
    if (bus.UPDATED) upd_cnt++;
    seen |= ~bus.AN;
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.DATA = d; bus.DP = dp; bus.EN = en; bus.LOAD = 1'b1;
    step();
    bus.LOAD = 1'b0;
  endtask

  task automatic wait_upd(input string tag);
    for (int i = 0; i < 80 && !bus.UPDATED; i++) step();
    chk(tag, bus.UPDATED, 1);
  endtask

  task automatic run_to_slot(input int slot, input int pre);
    for (int i = 0; i < 80 && !((mcyc / D) % 8 == slot && mcyc % D == pre); i++) step();
    chk("sync", (mcyc / D) % 8 * D + mcyc % D, slot * D + pre);
  endtask

  initial begin
    bus.DATA = 0; bus.DP = 0; bus.EN = 0; bus.LOAD = 0;
    repeat (3) step();
    chk("rst_ca", bus.CA, 8'hFF);
    chk("rst_an", bus.AN, 8'hFF);
    chk("rst_upd", bus.UPDATED, 0);
    rst = 1'b0;
    seen = 0;
    repeat (40) step();
    chk("idle_blank", seen, 8'h00);
    // scan order and glyphs
    load(32'h76543210, 8'h00, 8'hFF);
    wait_upd("scan_upd");
    for (int k = 0; k < 8; k++) begin
      chk("scan_an", bus.AN, an_tab[k]);
      chk("scan_ca", bus.CA, segt[k]);
      if (k < 7) repeat (D) step();
    end
    // last-wins
    run_to_slot(0, 1);
    upd_cnt = 0;
    load(32'h11111111, 8'h00, 8'hFF);
    repeat (5) step();
    load(32'h22222222, 8'h00, 8'hFF);
    wait_upd("lw_upd");
    chk("lw_ca", bus.CA, 8'hA4);
    repeat (70) step();
    chk("lw_pulses", upd_cnt, 1);
    // LOAD exactly on the frame-boundary tick
    run_to_slot(7, D - 1);
    load(32'hFFFFFFFF, 8'h00, 8'hFF);
    chk("col_upd", bus.UPDATED, 1);
    chk("col_ca", bus.CA, 8'h8E);
    run_to_slot(7, D - 1);
    load(32'hFFFFFFFF, 8'h01, 8'hFF);
    chk("col_dp_upd", bus.UPDATED, 1);
    chk("col_dp_ca", bus.CA, 8'h0E);
    chk("col_dp_an", bus.AN, 8'hFE);
    // reset mid-frame with a pending LOAD
    run_to_slot(3, 1);
    load(32'h89ABCDEF, 8'hFF, 8'hFF);
    rst = 1'b1;
    repeat (2) step();
    chk("mrst_an", bus.AN, 8'hFF);
    rst = 1'b0;
    upd_cnt = 0;
    seen = 0;
    repeat (80) step();
    chk("mrst_pulses", upd_cnt, 0);
    chk("mrst_blank", seen, 8'h00);
    // leading-zero handling
    load(32'h000000A5, 8'h00, 8'hFF);
    wait_upd("lz_upd");
    seen = 0;
    repeat (8 * D) step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_seen", seen, 8'h03);
`else
    chk("lz_seen", seen, 8'hFF);
`endif
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.DATA = $urandom >> $urandom_range(31, 0);
      bus.DP = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
      bus.EN = ($urandom_range(1, 0) == 0) ? 8'hFF : 8'($urandom);
      bus.LOAD = $urandom_range(15, 0) == 0;
      rst = $urandom_range(400, 0) == 0;
      step();
    end
    rst = 1'b0;
    bus.LOAD = 1'b0;
    repeat (40) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port DATA, input, 32 bits: eight hex nibbles; nibble k (DATA[4k+3:4k]) drives digit k.
REQ-005 SHALL have port DP, input, 8 bits: decimal point request per digit, 1 = lit.
REQ-006 SHALL have port EN, input, 8 bits: digit enable mask, 1 = digit shown.
REQ-007 SHALL have port LOAD, input, 1 bit: single-cycle strobe that captures DATA, DP and EN.
REQ-008 SHALL have port UPDATED, output, 1 bit: one-cycle pulse when captured values become the active display.
REQ-009 SHALL have port CA, output, 8 bits, active-low segment cathodes: CA[0]=a ... CA[6]=g, CA[7]=DP.
REQ-010 SHALL have port AN, output, 8 bits, active-low digit anodes: AN[k] selects digit k.

Function
REQ-011 SHALL run a prescaler from 0 to REFRESH_DIV-1 and wrap to 0; a tick SHALL occur on the terminal-count cycle.
REQ-012 SHALL advance a 3-bit digit index on each tick, wrapping from 7 to 0; a tick with index 7 SHALL be the frame boundary.
REQ-013 CA and AN SHALL be registered and SHALL reflect the new index on the cycle after the tick.
REQ-014 AN SHALL be ~(8'b1 << idx) when active EN[idx]=1 and the digit is not blanked; otherwise AN SHALL be 8'hFF.
REQ-015 Hex digits 0-F SHALL decode to CA[6:0] values C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (CA[7]=1), i.e. 0->8'hC0 ... F->8'h8E.
REQ-016 CA[7] SHALL be 0 exactly when active DP[idx]=1 and the digit is shown.
REQ-017 A blanked or disabled digit SHALL drive CA=8'hFF.
REQ-018 LOAD SHALL copy DATA/DP/EN into a pending buffer and set a pending flag; active values SHALL change only at a frame boundary.
REQ-019 At a frame boundary with pending set, active SHALL take the pending values, the flag SHALL clear, and UPDATED SHALL pulse on the following cycle.
REQ-020 Multiple LOADs within one frame SHALL be last-wins, producing exactly one UPDATED pulse.
REQ-021 LOAD coincident with a boundary SHALL load that cycle's DATA/DP/EN directly into active, clear pending, and pulse UPDATED once.
REQ-022 With no pending data at a boundary, active values SHALL be unchanged and UPDATED SHALL stay 0.

Reset
REQ-023 While RST=1: prescaler=0, idx=0, pending flag=0, active and pending DATA/DP/EN=0, CA=8'hFF, AN=8'hFF, UPDATED=0; all SHALL hold on the clock edge after RST is sampled high.
REQ-024 RST mid-frame SHALL discard pending and active contents; scanning SHALL restart at digit 0 with prescaler 0 on the first cycle after RST falls.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digits above the most significant nonzero active nibble SHALL be blanked unless their DP bit is set; digit 0 SHALL never be blanked by this rule.
REQ-026 Without LEADING_ZERO_BLANK_EN, every enabled digit SHALL be shown, zeros included.

Verification (REFRESH_DIV=4)
REQ-027 Reset: hold RST=1 for 3 cycles -> CA=FF, AN=FF, UPDATED=0; with no LOAD, outputs remain FF indefinitely.
REQ-028 Scan: LOAD DATA=32'h76543210, EN=FF, DP=00 -> UPDATED at the next boundary; AN steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles, with CA C0,F9,A4,B0,99,92,82,F8.
REQ-029 Last-wins: LOAD 32'h11111111 then 32'h22222222 within one frame -> one UPDATED pulse; every digit shows CA=A4.
REQ-030 Boundary collision: LOAD 32'hFFFFFFFF on the idx-7 tick cycle -> UPDATED the next cycle; digit 0 shows CA=8E; DP[0]=1 gives CA=0E.
REQ-031 Mid-frame reset: RST asserted at idx=3 with a LOAD pending -> AN=FF; after release no UPDATED pulse and the display stays blank.
REQ-032 Macro: DATA=32'h000000A5, EN=FF -> with LEADING_ZERO_BLANK_EN only AN FE/FD activate; without it all eight digits activate, digits 2-7 showing C0.
